// File: rtl/memmap_pkg.sv
// Shared constants for the CPU-side memory map: I/O register offsets,
// keyboard status bit positions and window target ids.
package memmap_pkg;

  localparam logic [2:0] IO_BANK      = 3'd0;
  localparam logic [2:0] IO_WINSEL    = 3'd1;
  localparam logic [2:0] IO_VIDEOMODE = 3'd2;
  localparam logic [2:0] IO_CURX      = 3'd3;
  localparam logic [2:0] IO_CURY      = 3'd4;
  localparam logic [2:0] IO_KBDDATA   = 3'd5;
  localparam logic [2:0] IO_KBDSTAT   = 3'd6;
  localparam logic [2:0] IO_RSVD      = 3'd7;

  // KBD_STAT read bits
  localparam int KS_NONEMPTY = 0;
  localparam int KS_OVF      = 1;
  localparam int KS_FULL     = 2;
  // KBD_STAT write command bits
  localparam int KS_CLR_OVF  = 1;
  localparam int KS_FLUSH    = 7;

  localparam int TGT_TEXT = 0;
  localparam int TGT_GRPH = 1;
  localparam int TGT_EXT  = 2;

endpackage

// File: rtl/memmap_ctrl_kbd_fifo.sv
// Circular PS/2 scancode FIFO with sticky overflow; pointers carry an extra
// wrap bit so full and empty are distinguishable without a counter.
module kbd_fifo #(
  parameter int KBD_AW = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_push,
  input  logic [7:0] i_din,
  input  logic       i_pop,
  input  logic       i_flush,
  input  logic       i_clr_ovf,
  output logic [7:0] o_head,
  output logic       o_full,
  output logic       o_empty,
  output logic       o_overflow
);

  localparam int DEPTH = 2 ** KBD_AW;

  logic [KBD_AW:0] r_wr_ptr;
  logic [KBD_AW:0] r_rd_ptr;
  logic [7:0]      r_mem [DEPTH];
  logic            r_overflow;

  logic w_empty;
  logic w_full;
  logic w_do_pop;
  logic w_do_push;
  logic w_drop;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[KBD_AW] != r_rd_ptr[KBD_AW]) &&
                   (r_wr_ptr[KBD_AW-1:0] == r_rd_ptr[KBD_AW-1:0]);

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_do_pop  = i_pop & ~w_empty & ~i_flush;
  assign w_do_push = i_push & ~i_flush & (~w_full | w_do_pop);
  assign w_drop    = i_push & ~i_flush & w_full & ~w_do_pop;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (i_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_drop)         r_overflow <= 1'b1;
      else if (i_clr_ovf) r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[KBD_AW-1:0]] <= i_din;
  end

  assign o_head     = r_mem[r_rd_ptr[KBD_AW-1:0]];
  assign o_full     = w_full;
  assign o_empty    = w_empty;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/memmap_ctrl.sv
// CPU data-bus decoder: SRAM, bank-switched window onto NTGT target memories,
// and an 8-entry I/O register file fronting video state and the scancode FIFO.
module memmap_ctrl
  import memmap_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                BANK_W   = 8,
  parameter int                WIN_AW   = 12,
  parameter logic [ADDR_W-1:0] WIN_BASE = 16'hF000,
  parameter logic [ADDR_W-1:0] IO_BASE  = 16'h0020,
  parameter int                NTGT     = 3,
  parameter int                KBD_AW   = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              wren,
  input  logic              rden,
  input  logic [7:0]        data_o,
  output logic [7:0]        data_i,
  input  logic [7:0]        data_o_sram,
  input  logic [8*NTGT-1:0] data_o_win,
  output logic              data_w_sram,
  output logic [NTGT-1:0]   data_w_win,
  output logic [BANK_W-1:0] bank,
  output logic [7:0]        videomode,
  output logic [7:0]        cursor_x,
  output logic [7:0]        cursor_y,
  input  logic [7:0]        ps2_data,
  input  logic              ps2_hit,
  output logic              kbd_irq
);

  localparam int SEL_W = (NTGT > 1) ? $clog2(NTGT) : 1;

  logic [BANK_W-1:0] r_bank;
  logic [SEL_W-1:0]  r_win_sel;
  logic [7:0]        r_videomode;
  logic [7:0]        r_cursor_x;
  logic [7:0]        r_cursor_y;

  logic [ADDR_W-1:0] w_io_diff;
  logic [2:0]        w_io_off;
  logic              w_is_io;
  logic              w_is_win;
  logic              w_is_sram;
  logic              w_io_wr;
  logic              w_io_rd;
  logic [7:0]        w_win_rd;
  logic [NTGT-1:0]   w_win_we;
  logic [7:0]        w_io_rdata;
  logic [7:0]        w_kbd_stat;

  logic [7:0] w_fifo_head;
  logic       w_fifo_full;
  logic       w_fifo_empty;
  logic       w_fifo_ovf;
  logic       w_fifo_pop;
  logic       w_fifo_flush;
  logic       w_fifo_clr;

  // Decode priority: IO > WIN > SRAM.
  assign w_io_diff = address - IO_BASE;
  assign w_io_off  = w_io_diff[2:0];
  assign w_is_io   = (address >= IO_BASE) && (w_io_diff < ADDR_W'(8));
  assign w_is_win  = ~w_is_io && (address[ADDR_W-1:WIN_AW] == WIN_BASE[ADDR_W-1:WIN_AW]);
  assign w_is_sram = ~w_is_io & ~w_is_win;

  assign w_io_wr = wren & w_is_io;
  assign w_io_rd = rden & w_is_io;

  // An out-of-range win_sel matches no target: writes vanish, reads float high.
  always_comb begin
    w_win_rd = 8'hFF;
    w_win_we = '0;
    for (int k = 0; k < NTGT; k++) begin
      if (r_win_sel == SEL_W'(k)) begin
        w_win_rd    = data_o_win[8*k +: 8];
        w_win_we[k] = wren & w_is_win;
      end
    end
  end

  assign data_w_sram = wren & w_is_sram;
  assign data_w_win  = w_win_we;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_bank      <= '0;
      r_win_sel   <= '0;
      r_videomode <= '0;
      r_cursor_x  <= '0;
      r_cursor_y  <= '0;
    end else if (w_io_wr) begin
      case (w_io_off)
        IO_BANK:      r_bank      <= data_o[BANK_W-1:0];
        IO_WINSEL:    r_win_sel   <= data_o[SEL_W-1:0];
        IO_VIDEOMODE: r_videomode <= data_o;
        IO_CURX:      r_cursor_x  <= data_o;
        IO_CURY:      r_cursor_y  <= data_o;
        default: ;
      endcase
    end
  end

  assign w_fifo_pop   = w_io_rd & (w_io_off == IO_KBDDATA);
  assign w_fifo_flush = w_io_wr & (w_io_off == IO_KBDSTAT) & data_o[KS_FLUSH];
  assign w_fifo_clr   = w_io_wr & (w_io_off == IO_KBDSTAT) & data_o[KS_CLR_OVF];

  kbd_fifo #(.KBD_AW(KBD_AW)) u_kbd_fifo (
    .i_clk      (clock),
    .i_rst      (reset),
    .i_push     (ps2_hit),
    .i_din      (ps2_data),
    .i_pop      (w_fifo_pop),
    .i_flush    (w_fifo_flush),
    .i_clr_ovf  (w_fifo_clr),
    .o_head     (w_fifo_head),
    .o_full     (w_fifo_full),
    .o_empty    (w_fifo_empty),
    .o_overflow (w_fifo_ovf)
  );

  always_comb begin
    w_kbd_stat              = '0;
    w_kbd_stat[KS_NONEMPTY] = ~w_fifo_empty;
    w_kbd_stat[KS_OVF]      = w_fifo_ovf;
    w_kbd_stat[KS_FULL]     = w_fifo_full;
  end

  always_comb begin
    w_io_rdata = 8'h00;
    case (w_io_off)
      IO_BANK:      w_io_rdata = 8'(r_bank);
      IO_WINSEL:    w_io_rdata = 8'(r_win_sel);
      IO_VIDEOMODE: w_io_rdata = r_videomode;
      IO_CURX:      w_io_rdata = r_cursor_x;
      IO_CURY:      w_io_rdata = r_cursor_y;
      IO_KBDDATA:   w_io_rdata = w_fifo_empty ? 8'h00 : w_fifo_head;
      IO_KBDSTAT:   w_io_rdata = w_kbd_stat;
      IO_RSVD:      w_io_rdata = 8'h00;
      default:      w_io_rdata = 8'h00;
    endcase
  end

  always_comb begin
    data_i = data_o_sram;
    if (w_is_io)       data_i = w_io_rdata;
    else if (w_is_win) data_i = w_win_rd;
  end

  assign bank      = r_bank;
  assign videomode = r_videomode;
  assign cursor_x  = r_cursor_x;
  assign cursor_y  = r_cursor_y;
  // Derived only from registered FIFO pointers, never from ps2_hit directly.
  assign kbd_irq   = ~w_fifo_empty;

endmodule

// File: tb/tb_memmap_ctrl.sv
// Directed and randomized bench for memmap_ctrl against a queue-based model
// of the memory map and scancode FIFO.
module tb_memmap_ctrl;

  localparam logic [15:0] IO_BASE = 16'h0020;
  localparam int          FDEPTH  = 16;

  logic        clock;
  logic        reset;
  logic [15:0] address;
  logic        wren;
  logic        rden;
  logic [7:0]  data_o;
  logic [7:0]  data_i;
  logic [7:0]  data_o_sram;
  logic [23:0] data_o_win;
  logic        data_w_sram;
  logic [2:0]  data_w_win;
  logic [7:0]  bank;
  logic [7:0]  videomode;
  logic [7:0]  cursor_x;
  logic [7:0]  cursor_y;
  logic [7:0]  ps2_data;
  logic        ps2_hit;
  logic        kbd_irq;

  memmap_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .address     (address),
    .wren        (wren),
    .rden        (rden),
    .data_o      (data_o),
    .data_i      (data_i),
    .data_o_sram (data_o_sram),
    .data_o_win  (data_o_win),
    .data_w_sram (data_w_sram),
    .data_w_win  (data_w_win),
    .bank        (bank),
    .videomode   (videomode),
    .cursor_x    (cursor_x),
    .cursor_y    (cursor_y),
    .ps2_data    (ps2_data),
    .ps2_hit     (ps2_hit),
    .kbd_irq     (kbd_irq)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // reference model state
  logic [7:0] m_bank, m_vm, m_cx, m_cy;
  logic [1:0] m_sel;
  logic       m_ovf;
  logic [7:0] m_q[$];

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fail_cnt  = 0;

  task automatic model_reset();
    m_bank = 0; m_sel = 0; m_vm = 0; m_cx = 0; m_cy = 0; m_ovf = 0;
    m_q.delete();
  endtask

  function automatic bit is_io(input logic [15:0] a);
    return (a >= IO_BASE) && (a < IO_BASE + 16'd8);
  endfunction

  function automatic bit is_win(input logic [15:0] a);
    return !is_io(a) && (a >= 16'hF000);
  endfunction

  function automatic logic [7:0] exp_rd(input logic [15:0] a);
    int off;
    if (is_io(a)) begin
      off = int'(a - IO_BASE);
      case (off)
        0: return m_bank;
        1: return {6'b0, m_sel};
        2: return m_vm;
        3: return m_cx;
        4: return m_cy;
        5: return (m_q.size() > 0) ? m_q[0] : 8'h00;
        6: return {5'b0, m_q.size() == FDEPTH, m_ovf, m_q.size() != 0};
        default: return 8'h00;
      endcase
    end
    if (is_win(a)) return (m_sel < 3) ? data_o_win[int'(m_sel)*8 +: 8] : 8'hFF;
    return data_o_sram;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [2:0] exp_we;
    exp_we = 3'b000;
    if (wren && is_win(address) && m_sel < 3) exp_we[m_sel] = 1'b1;
    chk({tag, ".data_i"}, 32'(data_i), 32'(exp_rd(address)));
    chk({tag, ".w_sram"}, 32'(data_w_sram), 32'(wren && !is_io(address) && !is_win(address)));
    chk({tag, ".w_win"}, 32'(data_w_win), 32'(exp_we));
    chk({tag, ".bank"}, 32'(bank), 32'(m_bank));
    chk({tag, ".vm"}, 32'(videomode), 32'(m_vm));
    chk({tag, ".cx"}, 32'(cursor_x), 32'(m_cx));
    chk({tag, ".cy"}, 32'(cursor_y), 32'(m_cy));
    chk({tag, ".irq"}, 32'(kbd_irq), 32'(m_q.size() != 0));
  endtask

  task automatic model_update(input logic [15:0] a, input logic w, input logic r,
                              input logic [7:0] wd, input logic h, input logic [7:0] pd);
    int  pre;
    int  off;
    bit  popped, flush, drop;
    pre = m_q.size();
    off = is_io(a) ? int'(a - IO_BASE) : -1;
    popped = 0; drop = 0;
    if (r && off == 5 && pre > 0) begin
      void'(m_q.pop_front());
      popped = 1;
    end
    flush = w && off == 6 && wd[7];
    if (flush) m_q.delete();
    else if (h) begin
      if (pre < FDEPTH || popped) m_q.push_back(pd);
      else drop = 1;
    end
    if (drop) m_ovf = 1;
    else if (w && off == 6 && wd[1]) m_ovf = 0;
    if (w) begin
      case (off)
        0: m_bank = wd;
        1: m_sel  = wd[1:0];
        2: m_vm   = wd;
        3: m_cx   = wd;
        4: m_cy   = wd;
        default: ;
      endcase
    end
  endtask

  // driver: one bus cycle, checked before the edge, model advanced at the edge
  task automatic step(input string tag, input logic [15:0] a, input logic w, input logic r,
                      input logic [7:0] wd, input logic h, input logic [7:0] pd);
    address = a; wren = w; rden = r; data_o = wd; ps2_hit = h; ps2_data = pd;
    data_o_sram = 8'($urandom);
    data_o_win  = 24'($urandom);
    #2;
    check_outputs(tag);
    @(posedge clock);
    model_update(a, w, r, wd, h, pd);
    #1;
    wren = 0; rden = 0; ps2_hit = 0;
  endtask

  initial begin
    logic [15:0] ra;
    logic [7:0]  rwd;
    int          kind;

    reset = 1; address = 16'h0100; wren = 0; rden = 0; data_o = 0;
    data_o_sram = 0; data_o_win = 0; ps2_data = 0; ps2_hit = 0;
    model_reset();
    #12;
    check_outputs("por");
    @(negedge clock);
    reset = 0;
    @(posedge clock); #1;

    // mid-run reset after register write and 3 pushes
    step("pre_rst_bank", IO_BASE + 16'd0, 1, 0, 8'h5A, 0, 0);
    step("push_a", 16'h0100, 0, 0, 0, 1, 8'h11);
    step("push_b", 16'h0100, 0, 0, 0, 1, 8'h22);
    step("push_c", 16'h0100, 0, 0, 0, 1, 8'h33);
    address = IO_BASE + 16'd6;
    #1;
    reset = 1;
    #1;
    model_reset();
    check_outputs("async_rst");
    chk("rst_kbdstat", 32'(data_i), 32'h00);
    @(negedge clock);
    reset = 0;
    @(posedge clock); #1;

    // window write with bank 5, target 1
    step("wr_bank", IO_BASE + 16'd0, 1, 0, 8'h05, 0, 0);
    step("wr_sel", IO_BASE + 16'd1, 1, 0, 8'h01, 0, 0);
    step("win_wr", 16'hF123, 1, 0, 8'hAB, 0, 0);
    chk("bank_is_5", 32'(bank), 32'h05);

    // two scancodes out in order, then empty
    step("push_1c", 16'h0100, 0, 0, 0, 1, 8'h1C);
    step("push_32", 16'h0100, 0, 0, 0, 1, 8'h32);
    step("rd_1c", IO_BASE + 16'd5, 0, 1, 0, 0, 0);
    step("rd_32", IO_BASE + 16'd5, 0, 1, 0, 0, 0);
    step("rd_empty", IO_BASE + 16'd5, 0, 1, 0, 0, 0);
    step("stat_empty", IO_BASE + 16'd6, 0, 1, 0, 0, 0);

    // overfill by one, then clear overflow
    for (int i = 0; i < 17; i++) step("fill", 16'h0100, 0, 0, 0, 1, 8'(8'h40 + i));
    step("stat_full_ovf", IO_BASE + 16'd6, 0, 1, 0, 0, 0);
    step("clr_ovf", IO_BASE + 16'd6, 1, 0, 8'h02, 0, 0);
    step("stat_full", IO_BASE + 16'd6, 0, 1, 0, 0, 0);

    // full: pop and push together
    step("pop_push_full", IO_BASE + 16'd5, 0, 1, 0, 1, 8'hEE);
    step("stat_after_pp", IO_BASE + 16'd6, 0, 1, 0, 0, 0);
    step("head_after_pp", IO_BASE + 16'd5, 0, 0, 0, 0, 0);

    // flush beats a concurrent scancode
    step("flush_hit", IO_BASE + 16'd6, 1, 0, 8'h80, 1, 8'h77);
    step("stat_flushed", IO_BASE + 16'd6, 0, 1, 0, 0, 0);

    // invalid window target, then SRAM access
    step("sel3", IO_BASE + 16'd1, 1, 0, 8'h03, 0, 0);
    step("rd_sel3", IO_BASE + 16'd1, 0, 1, 0, 0, 0);
    step("win_ff", 16'hF000, 0, 1, 0, 0, 0);
    step("win_wr_drop", 16'hF000, 1, 0, 8'h12, 0, 0);
    step("sram_rd", 16'h0100, 0, 1, 0, 0, 0);
    step("sram_wr", 16'h0100, 1, 0, 8'h34, 0, 0);
    step("io_edge_lo", IO_BASE - 16'd1, 1, 0, 8'h9, 0, 0);
    step("io_edge_hi", IO_BASE + 16'd8, 1, 0, 8'h9, 0, 0);
    step("rsvd", IO_BASE + 16'd7, 1, 1, 8'hFF, 0, 0);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      kind = $urandom_range(0, 9);
      if (kind < 5)      ra = IO_BASE + 16'($urandom_range(0, 7));
      else if (kind < 7) ra = 16'hF000 | 16'($urandom_range(0, 16'h0FFF));
      else if (kind < 8) ra = (($urandom_range(0, 1) == 0) ? IO_BASE - 16'd1 : IO_BASE + 16'd8);
      else               ra = 16'($urandom_range(0, 16'hEFFF));
      rwd = 8'($urandom);
      if (ra == IO_BASE + 16'd6 && $urandom_range(0, 7) != 0) rwd[7] = 1'b0;
      step("rand", ra, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), rwd,
           1'($urandom_range(0, 9) < 5), 8'($urandom));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
